// File: rtl/multicycle_control_fsm_if.sv
// rtl/multicycle_control_fsm_if.sv - control/datapath signal bundle for the multi-cycle RV32I sequencer
interface multicycle_control_fsm_if;
  logic [6:0] opcode;
  logic       bcond;
  logic       halt_cond;
  logic       mem_ready;
  logic       pc_write;
  logic [1:0] pc_source;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       mem_to_reg;
  logic       pc_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       is_ecall;
  logic       halted;
  logic       mem_timeout;
  logic [2:0] state;

  modport master (
    input  opcode, bcond, halt_cond, mem_ready,
    output pc_write, pc_source, iord, mem_read, mem_write, ir_write,
           reg_write, mem_to_reg, pc_to_reg, alu_src_a, alu_src_b,
           alu_op, is_ecall, halted, mem_timeout, state
  );

  modport slave (
    output opcode, bcond, halt_cond, mem_ready,
    input  pc_write, pc_source, iord, mem_read, mem_write, ir_write,
           reg_write, mem_to_reg, pc_to_reg, alu_src_a, alu_src_b,
           alu_op, is_ecall, halted, mem_timeout, state
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - IF/ID/EX/MEM/WB/HALT sequencer for the multi-cycle RV32I core
// Optional MC_PERF_CNT_EN adds cycle_count/instret performance counters.
module multicycle_control_fsm #(
  parameter int unsigned MEM_WAIT_MAX = 0
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MC_PERF_CNT_EN
  output logic [31:0] cycle_count,
  output logic [31:0] instret,
`endif
  multicycle_control_fsm_if.master bus
);

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

  logic [2:0]  state_q;
  logic [2:0]  state_d;
  logic [31:0] wait_cnt;
  logic        waiting;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    bus.pc_write   = 1'b0;
    bus.pc_source  = 2'b00;
    bus.iord       = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.pc_to_reg  = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    bus.is_ecall   = 1'b0;
    bus.halted     = 1'b0;
    case (state_q)
      S_IF: begin
        bus.mem_read = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          state_d      = S_ID;
        end
      end
      S_ID: begin
        // ALUOut <= PC + imm, the branch target consumed in EX
        bus.alu_src_b = 2'b10;
        case (bus.opcode)
          OP_ARITH, OP_ARITH_IMM, OP_LOAD, OP_STORE,
          OP_BRANCH, OP_JAL, OP_JALR: state_d = S_EX;
          OP_SYSTEM: begin
            bus.is_ecall = 1'b1;
            if (bus.halt_cond) begin
              state_d = S_HALT;
            end else begin
              bus.pc_write = 1'b1;
              state_d      = S_IF;
            end
          end
          default: begin
            bus.pc_write = 1'b1;
            state_d      = S_IF;
          end
        endcase
      end
      S_EX: begin
        state_d = S_WB;
        case (bus.opcode)
          OP_ARITH: begin
            bus.alu_src_a = 1'b1;
            bus.alu_op    = 2'b10;
          end
          OP_ARITH_IMM: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'b10;
            bus.alu_op    = 2'b10;
          end
          OP_LOAD, OP_STORE: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'b10;
            state_d       = S_MEM;
          end
          OP_BRANCH: begin
            bus.alu_src_a = 1'b1;
            bus.alu_op    = 2'b01;
            bus.pc_write  = 1'b1;
            bus.pc_source = bus.bcond ? 2'b01 : 2'b00;
            state_d       = S_IF;
          end
          OP_JAL: begin
            bus.alu_src_b = 2'b10;
          end
          OP_JALR: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'b10;
          end
          default: state_d = S_IF;
        endcase
      end
      S_MEM: begin
        bus.iord      = 1'b1;
        bus.mem_read  = (bus.opcode == OP_LOAD);
        bus.mem_write = (bus.opcode == OP_STORE);
        if (bus.mem_ready) begin
          if (bus.opcode == OP_LOAD) begin
            state_d = S_WB;
          end else begin
            bus.pc_write = (bus.opcode == OP_STORE);
            state_d      = S_IF;
          end
        end
      end
      S_WB: begin
        bus.reg_write = 1'b1;
        bus.pc_write  = 1'b1;
        state_d       = S_IF;
        if (bus.opcode == OP_LOAD) begin
          bus.mem_to_reg = 1'b1;
        end
        if (bus.opcode == OP_JAL || bus.opcode == OP_JALR) begin
          bus.pc_to_reg = 1'b1;
          bus.pc_source = 2'b01;
        end
      end
      S_HALT: begin
        bus.halted = 1'b1;
      end
      default: state_d = S_IF;
    endcase
  end

  // Waiting never changes state, so leaving the wait condition is the only clear needed.
  assign waiting = (state_q == S_IF || state_q == S_MEM) && !bus.mem_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= 32'd0;
    end else if (waiting && MEM_WAIT_MAX != 32'd0) begin
      if (wait_cnt != MEM_WAIT_MAX) begin
        wait_cnt <= wait_cnt + 32'd1;
      end
    end else begin
      wait_cnt <= 32'd0;
    end
  end

  assign bus.mem_timeout = reset && waiting && (MEM_WAIT_MAX != 32'd0) &&
                           (wait_cnt == MEM_WAIT_MAX - 32'd1);
  assign bus.state       = state_q;

`ifdef MC_PERF_CNT_EN
  logic enter_halt;
  assign enter_halt = (state_d == S_HALT) && (state_q != S_HALT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count <= 32'd0;
      instret     <= 32'd0;
    end else begin
      if (state_q != S_HALT) begin
        cycle_count <= cycle_count + 32'd1;
      end
      instret <= instret + {31'd0, bus.pc_write} + {31'd0, enter_halt};
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - randomized scoreboard bench for multicycle_control_fsm
module tb_multicycle_control_fsm;
  localparam int WAIT_MAX = 4;
  localparam int C_ARITH = 0, C_ARITHI = 1, C_LOAD = 2, C_STORE = 3, C_BRANCH = 4;
  localparam int C_JAL = 5, C_JALR = 6, C_ECALL = 7, C_NOP = 8;

  typedef struct packed {
    logic [2:0] st;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       pc_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       is_ecall;
    logic       halted;
    logic       mem_timeout;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_fsm_if bus();
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_count;
  logic [31:0] instret;
`endif

  multicycle_control_fsm #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk),
    .reset(reset),
`ifdef MC_PERF_CNT_EN
    .cycle_count(cycle_count),
    .instret(instret),
`endif
    .bus(bus)
  );

  rec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc_no = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      rec_t e;
      rec_t a;
      e = exp_q.pop_front();
      a.st          = bus.state;
      a.pc_write    = bus.pc_write;
      a.pc_source   = bus.pc_source;
      a.iord        = bus.iord;
      a.mem_read    = bus.mem_read;
      a.mem_write   = bus.mem_write;
      a.ir_write    = bus.ir_write;
      a.reg_write   = bus.reg_write;
      a.mem_to_reg  = bus.mem_to_reg;
      a.pc_to_reg   = bus.pc_to_reg;
      a.alu_src_a   = bus.alu_src_a;
      a.alu_src_b   = bus.alu_src_b;
      a.alu_op      = bus.alu_op;
      a.is_ecall    = bus.is_ecall;
      a.halted      = bus.halted;
      a.mem_timeout = bus.mem_timeout;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_outputs #%0d: got state=%0d vec=%b, expected state=%0d vec=%b",
                 cyc_no, a.st, a[17:0], e.st, e[17:0]);
      end
      cyc_no++;
    end
  end

  function automatic rec_t blank(input logic [2:0] st);
    rec_t r;
    r = '0;
    r.st = st;
    return r;
  endfunction

  function automatic logic [6:0] opc(input int c);
    logic [6:0] nops [5];
    nops = '{7'h37, 7'h17, 7'h0F, 7'h00, 7'h7F};
    case (c)
      C_ARITH:  return 7'h33;
      C_ARITHI: return 7'h13;
      C_LOAD:   return 7'h03;
      C_STORE:  return 7'h23;
      C_BRANCH: return 7'h63;
      C_JAL:    return 7'h6F;
      C_JALR:   return 7'h67;
      C_ECALL:  return 7'h73;
      default:  return nops[$urandom_range(0, 4)];
    endcase
  endfunction

  task automatic step(input rec_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // waits cycles with mem_ready low, then one ready cycle
  task automatic mem_phase(input rec_t base, input int waits, input rec_t done_rec);
    for (int k = 1; k <= waits; k++) begin
      rec_t e;
      e = base;
      bus.mem_ready = 1'b0;
      bus.bcond = 1'($urandom_range(0, 1));
      e.mem_timeout = (k == WAIT_MAX);
      step(e);
    end
    bus.mem_ready = 1'b1;
    bus.bcond = 1'($urandom_range(0, 1));
    step(done_rec);
  endtask

  task automatic run_instr(input int c, input int wif, input int wmem, input int bc, input bit hc);
    rec_t b;
    rec_t d;
    logic bcv;
    bus.opcode = opc(c);
    b = blank(3'd0);
    b.mem_read = 1'b1;
    d = b;
    d.ir_write = 1'b1;
    mem_phase(b, wif, d);

    bus.mem_ready = 1'($urandom_range(0, 1));
    bus.bcond = 1'($urandom_range(0, 1));
    bus.halt_cond = hc;
    d = blank(3'd1);
    d.alu_src_b = 2'b10;
    if (c == C_ECALL || c == C_NOP) begin
      d.is_ecall = (c == C_ECALL);
      if (c == C_ECALL && hc) begin
        step(d);
        return;
      end
      d.pc_write = 1'b1;
      step(d);
      return;
    end
    step(d);
    bus.halt_cond = 1'($urandom_range(0, 1));

    bcv = (bc < 0) ? 1'($urandom_range(0, 1)) : bc[0];
    bus.bcond = bcv;
    bus.mem_ready = 1'($urandom_range(0, 1));
    d = blank(3'd2);
    case (c)
      C_ARITH:  begin d.alu_src_a = 1'b1; d.alu_op = 2'b10; end
      C_ARITHI: begin d.alu_src_a = 1'b1; d.alu_src_b = 2'b10; d.alu_op = 2'b10; end
      C_LOAD, C_STORE, C_JALR: begin d.alu_src_a = 1'b1; d.alu_src_b = 2'b10; end
      C_JAL:    d.alu_src_b = 2'b10;
      default: begin
        d.alu_src_a = 1'b1;
        d.alu_op = 2'b01;
        d.pc_write = 1'b1;
        d.pc_source = bcv ? 2'b01 : 2'b00;
      end
    endcase
    step(d);
    if (c == C_BRANCH) return;

    if (c == C_LOAD || c == C_STORE) begin
      b = blank(3'd3);
      b.iord = 1'b1;
      b.mem_read = (c == C_LOAD);
      b.mem_write = (c == C_STORE);
      d = b;
      d.pc_write = (c == C_STORE);
      mem_phase(b, wmem, d);
      if (c == C_STORE) return;
    end

    bus.mem_ready = 1'($urandom_range(0, 1));
    bus.bcond = 1'($urandom_range(0, 1));
    d = blank(3'd4);
    d.reg_write = 1'b1;
    d.pc_write = 1'b1;
    d.mem_to_reg = (c == C_LOAD);
    if (c == C_JAL || c == C_JALR) begin
      d.pc_to_reg = 1'b1;
      d.pc_source = 2'b01;
    end
    step(d);
  endtask

  initial begin
    rec_t r;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cc0;
`endif
    bus.opcode = 7'h00;
    bus.bcond = 1'b0;
    bus.halt_cond = 1'b0;
    bus.mem_ready = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;

    r = blank(3'd0);
    r.mem_read = 1'b1;
    for (int i = 0; i < 2; i++) step(r);
    reset = 1'b1;

    run_instr(C_ARITH, 0, 0, -1, 1'b0);
    run_instr(C_LOAD, 0, 3, -1, 1'b0);
    run_instr(C_BRANCH, 0, 0, 1, 1'b0);
    run_instr(C_BRANCH, 0, 0, 0, 1'b0);
    run_instr(C_JALR, 0, 0, -1, 1'b0);
    run_instr(C_JAL, 0, 0, -1, 1'b0);
    run_instr(C_STORE, 1, 2, -1, 1'b0);
    run_instr(C_NOP, 0, 0, -1, 1'b0);
    run_instr(C_ECALL, 0, 0, -1, 1'b0);

    // timeout pulses once at the 4th wait, then reset lands mid-wait
    bus.opcode = opc(C_ARITH);
    for (int k = 1; k <= 6; k++) begin
      r = blank(3'd0);
      r.mem_read = 1'b1;
      r.mem_timeout = (k == WAIT_MAX);
      bus.mem_ready = 1'b0;
      step(r);
    end
    reset = 1'b0;
    r = blank(3'd0);
    r.mem_read = 1'b1;
    step(r);
    reset = 1'b1;
    run_instr(C_ARITH, 5, 0, -1, 1'b0);

    // reset during EX of a taken branch abandons it without a pc_write
    bus.opcode = opc(C_BRANCH);
    bus.mem_ready = 1'b1;
    r = blank(3'd0);
    r.mem_read = 1'b1;
    r.ir_write = 1'b1;
    step(r);
    r = blank(3'd1);
    r.alu_src_b = 2'b10;
    step(r);
    bus.bcond = 1'b1;
    bus.mem_ready = 1'b0;
    reset = 1'b0;
    r = blank(3'd0);
    r.mem_read = 1'b1;
    step(r);
    reset = 1'b1;
    run_instr(C_LOAD, 2, 5, -1, 1'b0);

    for (int i = 0; i < 60; i++) begin
      run_instr($urandom_range(0, 8), $urandom_range(0, 6), $urandom_range(0, 6), -1, 1'b0);
    end

    run_instr(C_ECALL, 0, 0, -1, 1'b1);
`ifdef MC_PERF_CNT_EN
    cc0 = cycle_count;
`endif
    r = blank(3'd5);
    r.halted = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.bcond = 1'($urandom_range(0, 1));
      bus.halt_cond = 1'($urandom_range(0, 1));
      bus.opcode = 7'($urandom_range(0, 127));
      step(r);
    end
`ifdef MC_PERF_CNT_EN
    checks++;
    if (cycle_count !== cc0) begin
      errors++;
      $display("FAIL cycle_count_frozen: got %0d, expected %0d", cycle_count, cc0);
    end
`endif

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d records left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
